// File: rtl/core_test_monitor.sv
// core_test_monitor: end-of-test judge for multi-hart regression runs.
// Latches per-hart exit/gp and issues a pass/fail or watchdog-timeout verdict.
module core_test_monitor #(
   parameter int          NUM_HARTS      = 1,
   parameter int          GP_WIDTH       = 32,
   parameter int unsigned PASS_VALUE     = 1,
   parameter int          TIMEOUT_CYCLES = 20000,
   parameter int          CNT_WIDTH      = 32,
   localparam int         FH_W           = $clog2(NUM_HARTS) + 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [NUM_HARTS-1:0]          exit,
   input  logic [NUM_HARTS*GP_WIDTH-1:0] gp,
   output logic                          done,
   output logic                          passed,
   output logic                          timed_out,
   output logic [NUM_HARTS-1:0]          exited,
   output logic [FH_W-1:0]               fail_hart,
   output logic [GP_WIDTH-1:0]           fail_gp,
   output logic [CNT_WIDTH-1:0]          cycle_count
);

   localparam logic [GP_WIDTH-1:0]  PASS_GP = GP_WIDTH'(PASS_VALUE);
   localparam bit                   TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                        state_q, state_d;
   logic [NUM_HARTS-1:0]          exited_q, exited_d;
   logic [NUM_HARTS*GP_WIDTH-1:0] gp_q, gp_d;
   logic                          done_q, done_d;
   logic                          passed_q, passed_d;
   logic                          to_q, to_d;
   logic [FH_W-1:0]               fh_q, fh_d;
   logic [GP_WIDTH-1:0]           fg_q, fg_d;
   logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;

   logic [NUM_HARTS-1:0]          ex_nx;
   logic [NUM_HARTS*GP_WIDTH-1:0] gp_nx;
   logic                          all_ex;
   logic                          bad;
   logic [FH_W-1:0]               bad_idx;
   logic [GP_WIDTH-1:0]           bad_gp;
   logic [FH_W-1:0]               miss_idx;

   // First exit of each hart wins; later pulses and gp changes are dropped.
   always_comb begin
      ex_nx = exited_q;
      gp_nx = gp_q;
      for (int i = 0; i < NUM_HARTS; i++) begin
         if (exit[i] && !exited_q[i]) begin
            ex_nx[i] = 1'b1;
            gp_nx[i*GP_WIDTH +: GP_WIDTH] = gp[i*GP_WIDTH +: GP_WIDTH];
         end
      end
      all_ex = &ex_nx;
   end

   // Descending scan so the lowest matching index is the one that sticks.
   always_comb begin
      bad      = 1'b0;
      bad_idx  = '1;
      bad_gp   = '0;
      miss_idx = '1;
      for (int i = NUM_HARTS - 1; i >= 0; i--) begin
         if (gp_nx[i*GP_WIDTH +: GP_WIDTH] != PASS_GP) begin
            bad     = 1'b1;
            bad_idx = FH_W'(i);
            bad_gp  = gp_nx[i*GP_WIDTH +: GP_WIDTH];
         end
         if (!ex_nx[i]) begin
            miss_idx = FH_W'(i);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      exited_d = exited_q;
      gp_d     = gp_q;
      done_d   = done_q;
      passed_d = passed_q;
      to_d     = to_q;
      fh_d     = fh_q;
      fg_d     = fg_q;
      cnt_d    = cnt_q;
      if (start) begin
         state_d  = RUN;
         exited_d = '0;
         gp_d     = '0;
         done_d   = 1'b0;
         passed_d = 1'b0;
         to_d     = 1'b0;
         fh_d     = '1;
         fg_d     = '0;
         cnt_d    = '0;
      end else begin
         unique case (state_q)
            IDLE: ;
            RUN: begin
               exited_d = ex_nx;
               gp_d     = gp_nx;
               // The last exit outranks a watchdog expiry on the same cycle.
               if (all_ex) begin
                  state_d  = DONE;
                  done_d   = 1'b1;
                  passed_d = !bad;
                  to_d     = 1'b0;
                  fh_d     = bad ? bad_idx : '1;
                  fg_d     = bad ? bad_gp : '0;
               end else if (TO_EN && cnt_q == TO_LAST) begin
                  state_d  = DONE;
                  done_d   = 1'b1;
                  passed_d = 1'b0;
                  to_d     = 1'b1;
                  fh_d     = miss_idx;
                  fg_d     = '0;
               end else if (cnt_q != '1) begin
                  cnt_d = cnt_q + CNT_WIDTH'(1);
               end
            end
            DONE: ;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         exited_q <= '0;
         gp_q     <= '0;
         done_q   <= 1'b0;
         passed_q <= 1'b0;
         to_q     <= 1'b0;
         fh_q     <= '1;
         fg_q     <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         exited_q <= exited_d;
         gp_q     <= gp_d;
         done_q   <= done_d;
         passed_q <= passed_d;
         to_q     <= to_d;
         fh_q     <= fh_d;
         fg_q     <= fg_d;
         cnt_q    <= cnt_d;
      end
   end

   assign done        = done_q;
   assign passed      = passed_q;
   assign timed_out   = to_q;
   assign exited      = exited_q;
   assign fail_hart   = fh_q;
   assign fail_gp     = fg_q;
   assign cycle_count = cnt_q;

endmodule

// File: tb/tb_core_test_monitor.sv
// tb_core_test_monitor: directed checks of core_test_monitor.
// One single-hart instance (no watchdog, 4-bit counter) and one 4-hart instance.
module tb_core_test_monitor;

   logic        clk;
   logic        rst;

   logic        start1;
   logic [0:0]  exit1;
   logic [31:0] gp1;
   logic        done1, passed1, to1;
   logic [0:0]  ex1;
   logic [0:0]  fh1;
   logic [31:0] fg1;
   logic [3:0]  cnt1;

   logic         start4;
   logic [3:0]   exit4;
   logic [127:0] gp4;
   logic         done4, passed4, to4;
   logic [3:0]   ex4;
   logic [2:0]   fh4;
   logic [31:0]  fg4;
   logic [31:0]  cnt4;

   int checks;
   int errors;

   core_test_monitor #(
      .NUM_HARTS(1), .GP_WIDTH(32), .PASS_VALUE(1),
      .TIMEOUT_CYCLES(0), .CNT_WIDTH(4)
   ) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .exit(exit1), .gp(gp1),
      .done(done1), .passed(passed1), .timed_out(to1), .exited(ex1),
      .fail_hart(fh1), .fail_gp(fg1), .cycle_count(cnt1)
   );

   core_test_monitor #(
      .NUM_HARTS(4), .GP_WIDTH(32), .PASS_VALUE(1),
      .TIMEOUT_CYCLES(100), .CNT_WIDTH(32)
   ) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .exit(exit4), .gp(gp4),
      .done(done4), .passed(passed4), .timed_out(to4), .exited(ex4),
      .fail_hart(fh4), .fail_gp(fg4), .cycle_count(cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      start1 = 1'b0;
      exit1  = '0;
      gp1    = '0;
      start4 = 1'b0;
      exit4  = '0;
      gp4    = '0;
      step();
      step();
      chk("rst_done1", done1, 0);
      chk("rst_fh1", fh1, 1'b1);
      chk("rst_cnt1", cnt1, 0);
      chk("rst_done4", done4, 0);
      chk("rst_fh4", fh4, 3'b111);
      chk("rst_ex4", ex4, 0);
      rst = 1'b0;
      step();

      // T1: single hart exits at RUN cycle 10 with gp=1
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      chk("t1_cnt0", cnt1, 0);
      repeat (9) step();
      chk("t1_cnt9", cnt1, 9);
      chk("t1_notdone", done1, 0);
      exit1 = 1'b1;
      gp1   = 32'd1;
      step();
      exit1 = 1'b0;
      chk("t1_done", done1, 1);
      chk("t1_passed", passed1, 1);
      chk("t1_to", to1, 0);
      chk("t1_fh", fh1, 1'b1);
      chk("t1_fg", fg1, 0);
      chk("t1_cnt", cnt1, 9);
      chk("t1_ex", ex1, 1);
      // exits in DONE are ignored
      exit1 = 1'b1;
      gp1   = 32'd5;
      repeat (2) step();
      exit1 = 1'b0;
      chk("t1_hold_pass", passed1, 1);
      chk("t1_hold_fg", fg1, 0);
      chk("t1_hold_cnt", cnt1, 9);

      // T2: re-arm from DONE, fail with gp=0x2B
      start1 = 1'b1;
      gp1    = 32'h2B;
      step();
      start1 = 1'b0;
      chk("t2_clr_done", done1, 0);
      chk("t2_clr_ex", ex1, 0);
      chk("t2_clr_cnt", cnt1, 0);
      chk("t2_clr_fh", fh1, 1'b1);
      exit1 = 1'b1;
      step();
      exit1 = 1'b0;
      chk("t2_done", done1, 1);
      chk("t2_passed", passed1, 0);
      chk("t2_to", to1, 0);
      chk("t2_fh", fh1, 0);
      chk("t2_fg", fg1, 32'h2B);

      // T6: next run judged independently -> pass
      start1 = 1'b1;
      gp1    = 32'd1;
      step();
      start1 = 1'b0;
      exit1  = 1'b1;
      step();
      exit1 = 1'b0;
      chk("t6_done", done1, 1);
      chk("t6_passed", passed1, 1);
      chk("t6_fh", fh1, 1'b1);
      chk("t6_fg", fg1, 0);

      // no watchdog: counter saturates at 15, no verdict
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      repeat (20) step();
      chk("sat_cnt", cnt1, 4'hF);
      chk("sat_done", done1, 0);
      chk("sat_to", to1, 0);
      rst = 1'b1;
      #1;
      chk("arst_cnt1", cnt1, 0);
      chk("arst_done1", done1, 0);
      step();
      rst = 1'b0;
      step();

      // T3: harts exit at cycles 5, 9, 9, 20; hart 1 gp changes later
      gp4    = {32'd1, 32'd1, 32'd1, 32'd1};
      start4 = 1'b1;
      step();
      start4 = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         exit4 = (c == 5)  ? 4'b0001 :
                 (c == 9)  ? 4'b0110 :
                 (c == 20) ? 4'b1000 : 4'b0000;
         if (c == 12) gp4[63:32] = 32'd7;
         step();
         if (c == 19) begin
            chk("t3_notdone", done4, 0);
            chk("t3_ex19", ex4, 4'b0111);
            chk("t3_cnt19", cnt4, 19);
         end
      end
      exit4 = 4'b0000;
      chk("t3_done", done4, 1);
      chk("t3_passed", passed4, 1);
      chk("t3_to", to4, 0);
      chk("t3_fh", fh4, 3'b111);
      chk("t3_cnt", cnt4, 19);

      // T4: hart 2 never exits -> timeout on the 100th RUN cycle
      gp4    = {32'd1, 32'd1, 32'd1, 32'd1};
      start4 = 1'b1;
      step();
      start4 = 1'b0;
      exit4  = 4'b1011;
      step();
      exit4 = 4'b0000;
      repeat (98) step();
      chk("t4_cnt99", cnt4, 99);
      chk("t4_notdone", done4, 0);
      step();
      chk("t4_done", done4, 1);
      chk("t4_to", to4, 1);
      chk("t4_passed", passed4, 0);
      chk("t4_fh", fh4, 2);
      chk("t4_fg", fg4, 0);
      chk("t4_cnt", cnt4, 99);
      chk("t4_ex", ex4, 4'b1011);

      // T5: last exit lands on the timeout cycle; hart 0 gp=3
      gp4    = {32'd1, 32'd1, 32'd1, 32'd3};
      start4 = 1'b1;
      step();
      start4 = 1'b0;
      exit4  = 4'b1011;
      step();
      exit4 = 4'b0000;
      repeat (98) step();
      exit4 = 4'b0100;
      step();
      exit4 = 4'b0000;
      chk("t5_done", done4, 1);
      chk("t5_to", to4, 0);
      chk("t5_passed", passed4, 0);
      chk("t5_fh", fh4, 0);
      chk("t5_fg", fg4, 3);
      chk("t5_ex", ex4, 4'b1111);

      // rst mid-run returns outputs to reset values at once
      start4 = 1'b1;
      step();
      start4 = 1'b0;
      exit4  = 4'b0001;
      step();
      exit4 = 4'b0000;
      repeat (3) step();
      chk("mid_cnt", cnt4, 4);
      chk("mid_ex", ex4, 4'b0001);
      rst = 1'b1;
      #1;
      chk("arst_ex4", ex4, 0);
      chk("arst_cnt4", cnt4, 0);
      chk("arst_fh4", fh4, 3'b111);
      chk("arst_fg4", fg4, 0);
      chk("arst_done4", done4, 0);
      chk("arst_vrd4", {passed4, to4}, 0);
      step();
      rst = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
